// File: rtl/tx_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_buffer_pkg : shared defaults and frame FSM state type          |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
package tx_buffer_pkg;

    localparam int c_DATA_W       = 64;
    localparam int c_ADDR_W       = 12;
    localparam int c_AFULL_MARGIN = 16;
    localparam int c_AFULL_TH     = (2**c_ADDR_W) - c_AFULL_MARGIN;

    typedef enum logic [0:0] {
        FRM_IDLE  = 1'b0,
        FRM_DRAIN = 1'b1
    } frame_state_e;

endpackage : tx_buffer_pkg
`default_nettype wire

// File: rtl/tx_buffer_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_buffer_ram : simple dual-port RAM, registered read port        |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module tx_buffer_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register reset maps onto the block-RAM output latch reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : tx_buffer_ram
`default_nettype wire

// File: rtl/tx_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_frame_buffer : FIFO with occupancy snapshot and frame drain    |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module tx_frame_buffer
    import tx_buffer_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int AFULL_TH = (ADDR_W == c_ADDR_W) ? c_AFULL_TH
                                                  : (2**ADDR_W) - c_AFULL_MARGIN
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [DATA_W-1:0] buffer_wr_data,
    input  logic              buffer_wr_en,
    input  logic              buffer_rd_en,
    output logic [DATA_W-1:0] buffer_rd_data,
    output logic              buffer_rd_valid,
    input  logic              read_start,
    output logic [ADDR_W:0]   buffer_data_count,
    output logic [ADDR_W:0]   frame_remaining,
    output logic              frame_done,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic              buffer_afull,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_AFULL = (ADDR_W+1)'(AFULL_TH);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rd_valid_q, done_q, done_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    frame_state_e      state_q, state_d;
    logic              wr_acc, rd_acc;

    assign buffer_full  = (occ_q == c_DEPTH);
    assign buffer_empty = (occ_q == '0);
    assign buffer_afull = (occ_q >= c_AFULL);

    // A full buffer rejects writes even when a read frees a slot this cycle.
    assign wr_acc = buffer_wr_en && !buffer_full;
    assign rd_acc = buffer_rd_en && !buffer_empty;

    tx_buffer_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (sclk),
        .rst       (s_rst),
        .wr_en_i   (wr_acc && !s_rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (buffer_wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (buffer_rd_data)
    );

    always_comb begin
        occ_d = occ_q;
        case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        ovf_d = (ovf_q && !err_clr) || (buffer_wr_en && buffer_full);
        udf_d = (udf_q && !err_clr) || (buffer_rd_en && buffer_empty);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            FRM_IDLE: begin
                if (read_start) begin
                    cnt_d   = occ_q;
                    rem_d   = occ_q;
                    state_d = FRM_DRAIN;
                end
            end
            FRM_DRAIN: begin
                // An exhausted frame (including an empty snapshot) closes one cycle after reaching zero.
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = FRM_IDLE;
                end else if (rd_acc) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            default: state_d = FRM_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            state_q    <= FRM_IDLE;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            occ_q      <= occ_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_acc;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            state_q    <= state_d;
        end
    end

    assign buffer_rd_valid   = rd_valid_q;
    assign buffer_data_count = cnt_q;
    assign frame_remaining   = rem_q;
    assign frame_done        = done_q;
    assign overflow          = ovf_q;
    assign underflow         = udf_q;

endmodule : tx_frame_buffer
`default_nettype wire

// File: tb/tb_tx_frame_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tx_frame_buffer : randomized bench against a queue model       |
// | Revision           : 1.0                                          |
// +------------------------------------------------------------------+
module tb_tx_frame_buffer;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;
    localparam int AFTH  = 12;

    logic          sclk = 1'b0;
    logic          s_rst = 1'b0;
    logic [DW-1:0] buffer_wr_data = '0;
    logic          buffer_wr_en = 1'b0;
    logic          buffer_rd_en = 1'b0;
    logic [DW-1:0] buffer_rd_data;
    logic          buffer_rd_valid;
    logic          read_start = 1'b0;
    logic [AW:0]   buffer_data_count;
    logic [AW:0]   frame_remaining;
    logic          frame_done;
    logic          buffer_full, buffer_empty, buffer_afull;
    logic          err_clr = 1'b0;
    logic          overflow, underflow;

    tx_frame_buffer #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AFULL_TH (AFTH)
    ) dut (
        .sclk              (sclk),
        .s_rst             (s_rst),
        .buffer_wr_data    (buffer_wr_data),
        .buffer_wr_en      (buffer_wr_en),
        .buffer_rd_en      (buffer_rd_en),
        .buffer_rd_data    (buffer_rd_data),
        .buffer_rd_valid   (buffer_rd_valid),
        .read_start        (read_start),
        .buffer_data_count (buffer_data_count),
        .frame_remaining   (frame_remaining),
        .frame_done        (frame_done),
        .buffer_full       (buffer_full),
        .buffer_empty      (buffer_empty),
        .buffer_afull      (buffer_afull),
        .err_clr           (err_clr),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, frame as "open" plus words left.
    logic [DW-1:0] mq[$];
    bit            m_open;
    int            m_rem, m_cnt;
    bit            m_done, m_rvalid, m_ovf, m_udf;
    logic [DW-1:0] m_rdata;
    int            m_wr_total;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("empty",   64'(buffer_empty),      64'(mq.size() == 0));
        check_eq("full",    64'(buffer_full),       64'(mq.size() == DEPTH));
        check_eq("afull",   64'(buffer_afull),      64'(mq.size() >= AFTH));
        check_eq("rvalid",  64'(buffer_rd_valid),   64'(m_rvalid));
        check_eq("rdata",   64'(buffer_rd_data),    64'(m_rdata));
        check_eq("dcount",  64'(buffer_data_count), 64'(m_cnt));
        check_eq("fremain", 64'(frame_remaining),   64'(m_rem));
        check_eq("fdone",   64'(frame_done),        64'(m_done));
        check_eq("ovf",     64'(overflow),          64'(m_ovf));
        check_eq("udf",     64'(underflow),         64'(m_udf));
    endtask

    task automatic cycle(input bit wr, input logic [DW-1:0] wd, input bit rd,
                         input bit rs, input bit ec);
        int  size_pre;
        bit  full, empty, wacc, racc, nd;
        size_pre = mq.size();
        full  = (size_pre == DEPTH);
        empty = (size_pre == 0);
        wacc  = wr && !full;
        racc  = rd && !empty;
        nd    = 1'b0;
        if (!m_open) begin
            if (rs) begin
                m_cnt  = size_pre;
                m_rem  = size_pre;
                m_open = 1'b1;
            end
        end else if (m_rem == 0) begin
            nd     = 1'b1;
            m_open = 1'b0;
        end else if (racc) begin
            m_rem--;
        end
        if (racc) m_rdata = mq.pop_front();
        m_rvalid = racc;
        if (wacc) begin
            mq.push_back(wd);
            m_wr_total++;
        end
        m_ovf  = (m_ovf && !ec) || (wr && full);
        m_udf  = (m_udf && !ec) || (rd && empty);
        m_done = nd;

        buffer_wr_en   = wr;
        buffer_wr_data = wd;
        buffer_rd_en   = rd;
        read_start     = rs;
        err_clr        = ec;
        @(posedge sclk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        s_rst        = 1'b1;
        buffer_wr_en = 1'b0;
        buffer_rd_en = 1'b0;
        read_start   = 1'b0;
        err_clr      = 1'b0;
        mq.delete();
        m_open = 0; m_rem = 0; m_cnt = 0; m_done = 0;
        m_rvalid = 0; m_ovf = 0; m_udf = 0; m_rdata = '0;
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0);
    endtask

    initial begin
        m_wr_total = 0;
        @(posedge sclk);
        #1;
        do_reset();

        // Five words, one frame, drain in order.
        for (int i = 1; i <= 5; i++) cycle(1, DW'(i), 0, 0, 0);
        cycle(0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);
        idle(3);

        // Fill, overflow, clear, then full with simultaneous write and read.
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'($urandom), 0, 0, 0);
        cycle(1, 16'hDEAD, 0, 0, 0);
        cycle(0, '0, 0, 0, 1);
        cycle(1, 16'hBEEF, 1, 0, 0);
        idle(1);
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0, 0);

        // Empty read and zero-word frame.
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 1, 1);
        idle(3);

        // Long random traffic across several pointer wraps.
        m_wr_total = 0;
        for (int c = 0; c < 3000 && m_wr_total < 3*DEPTH; c++) begin
            cycle(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
        end
        check_eq("wrap_words", 64'(m_wr_total >= 3*DEPTH), 64'd1);

        // Reset in the middle of a frame with three words left.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, DW'(i + 100), 0, 0, 0);
        cycle(0, '0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);
        check_eq("rem_before_rst", 64'(frame_remaining), 64'd3);
        do_reset();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tx_frame_buffer
`default_nettype wire
